// File: rtl/fabric_cfg_pkg.sv
// Shared types and constants for the fabric configuration loader:
// FSM states, header field layout and the fabric frame index map.
package fabric_cfg_pkg;

  localparam int unsigned WORD_W_DEF     = 33;
  localparam int unsigned NUM_FRAMES_DEF = 14;

  // Header word: sync byte in the top 8 bits, frame count N in the low 8 bits
  localparam logic [7:0]  SYNC_DEF = 8'hA5;
  localparam int unsigned SYNC_W   = 8;
  localparam int unsigned LEN_W    = 8;

  // Frame index map: select word, eight LUT words, then switch-box groups
  localparam int unsigned FRM_SELECT    = 0;
  localparam int unsigned FRM_LUT_BASE  = 1;
  localparam int unsigned FRM_LUT_COUNT = 8;
  localparam int unsigned FRM_SB_BASE   = FRM_LUT_BASE + FRM_LUT_COUNT;
  localparam int unsigned FRM_SB_COUNT  = NUM_FRAMES_DEF - FRM_SB_BASE;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HEADER,
    ST_LOAD,
    ST_CHECK,
    ST_DONE,
    ST_ERROR
  } state_e;

endpackage

// File: rtl/fabric_cfg_loader_if.sv
// Bitstream input, config write port and status bundle of the loader.
interface fabric_cfg_loader_if #(
  parameter int unsigned WORD_W = 33,
  parameter int unsigned ADDR_W = 4
);
  logic              start;
  logic [WORD_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic              cfg_we;
  logic [ADDR_W-1:0] cfg_addr;
  logic [WORD_W-1:0] cfg_wdata;
  logic              busy;
  logic              done;
  logic              error;
  logic              fabric_en;
  logic [ADDR_W:0]   frames_loaded;

  modport master (
    output start, in_data, in_valid,
    input  in_ready, cfg_we, cfg_addr, cfg_wdata, busy, done, error,
           fabric_en, frames_loaded
  );

  modport slave (
    input  start, in_data, in_valid,
    output in_ready, cfg_we, cfg_addr, cfg_wdata, busy, done, error,
           fabric_en, frames_loaded
  );
endinterface

// File: rtl/cfg_xor_accum.sv
// XOR accumulator over accepted data words; cleared at the start of each load.
module cfg_xor_accum #(
  parameter int unsigned WIDTH = 33
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] acc_o
);
  logic [WIDTH-1:0] acc_q, acc_d;

  always_comb begin
    acc_d = acc_q;
    if (clr_i)     acc_d = '0;
    else if (en_i) acc_d = acc_q ^ data_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) acc_q <= '0;
    else       acc_q <= acc_d;
  end

  assign acc_o = acc_q;
endmodule

// File: rtl/fabric_cfg_loader.sv
// Streaming configuration loader: header, N words -> registered cfg writes.
// CFG_LOADER_CHECKSUM_EN adds a trailing XOR checksum word and the CHECK state.
module fabric_cfg_loader
  import fabric_cfg_pkg::*;
#(
  parameter int unsigned WORD_W     = WORD_W_DEF,
  parameter int unsigned NUM_FRAMES = NUM_FRAMES_DEF,
  parameter int unsigned ADDR_W     = 4,
  parameter logic [7:0]  SYNC       = SYNC_DEF
) (
  input logic               clock,
  input logic               clear,
  fabric_cfg_loader_if.slave bus
);
  localparam int unsigned      CW   = ADDR_W + 1;
  localparam logic [LEN_W-1:0] NMAX = LEN_W'(NUM_FRAMES);

  state_e            state_q, state_d;
  logic [CW-1:0]     n_q, n_d, cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [WORD_W-1:0] wdata_q, wdata_d;

  logic              rdy, busy, done, err;
  logic              accept, restart, last_word, hdr_ok;
  logic [SYNC_W-1:0] hdr_sync;
  logic [LEN_W-1:0]  hdr_n;

  assign hdr_sync  = bus.in_data[WORD_W-1 -: SYNC_W];
  assign hdr_n     = bus.in_data[LEN_W-1:0];
  assign hdr_ok    = (hdr_sync == SYNC) && (hdr_n != '0) && (hdr_n <= NMAX);
  assign accept    = bus.in_valid && rdy;
  assign restart   = bus.start && (state_q inside {ST_IDLE, ST_DONE, ST_ERROR});
  assign last_word = (cnt_q + 1'b1) == n_q;

`ifdef CFG_LOADER_CHECKSUM_EN
  localparam state_e LOAD_EXIT = ST_CHECK;
  logic [WORD_W-1:0] acc;

  cfg_xor_accum #(.WIDTH(WORD_W)) u_accum (
    .clk_i  (clock),
    .rst_i  (clear),
    .clr_i  (restart),
    .en_i   ((state_q == ST_LOAD) && accept),
    .data_i (bus.in_data),
    .acc_o  (acc)
  );
`else
  localparam state_e LOAD_EXIT = ST_DONE;
`endif

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state_q <= ST_IDLE;
      n_q     <= '0;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  // Write strobe, address and count all update on the accepting edge,
  // so cfg_we and frames_loaded appear together one cycle after accept.
  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    cnt_d   = cnt_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    unique case (state_q)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (restart) begin
          state_d = ST_HEADER;
          n_d     = '0;
          cnt_d   = '0;
        end
      end
      ST_HEADER: begin
        if (accept) begin
          if (hdr_ok) begin
            n_d     = CW'(hdr_n);
            state_d = ST_LOAD;
          end else begin
            state_d = ST_ERROR;
          end
        end
      end
      ST_LOAD: begin
        if (accept) begin
          we_d    = 1'b1;
          addr_d  = cnt_q[ADDR_W-1:0];
          wdata_d = bus.in_data;
          cnt_d   = cnt_q + 1'b1;
          if (last_word) state_d = LOAD_EXIT;
        end
      end
`ifdef CFG_LOADER_CHECKSUM_EN
      ST_CHECK: begin
        if (accept) state_d = (bus.in_data == acc) ? ST_DONE : ST_ERROR;
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    rdy  = state_q inside {ST_HEADER, ST_LOAD, ST_CHECK};
    busy = rdy;
    done = (state_q == ST_DONE);
    err  = (state_q == ST_ERROR);
  end

  assign bus.in_ready      = rdy;
  assign bus.busy          = busy;
  assign bus.done          = done;
  assign bus.error         = err;
  assign bus.fabric_en     = done;
  assign bus.cfg_we        = we_q;
  assign bus.cfg_addr      = addr_q;
  assign bus.cfg_wdata     = wdata_q;
  assign bus.frames_loaded = cnt_q;
endmodule

// File: tb/tb_fabric_cfg_loader.sv
// Randomized self-checking bench for fabric_cfg_loader against a frame-level model.
module tb_fabric_cfg_loader;
  localparam int unsigned W  = 33;
  localparam int unsigned NF = 14;
  localparam int unsigned AW = 4;
  localparam int unsigned CW = AW + 1;

  logic clock = 1'b0;
  logic clear = 1'b1;

  fabric_cfg_loader_if #(.WORD_W(W), .ADDR_W(AW)) bus ();

  fabric_cfg_loader #(
    .WORD_W(W), .NUM_FRAMES(NF), .ADDR_W(AW), .SYNC(8'hA5)
  ) dut (
    .clock (clock),
    .clear (clear),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned wr_cnt = 0;
  logic [W-1:0] data_a [16];

  always @(negedge clock) if (bus.cfg_we === 1'b1) wr_cnt++;

  task automatic step(input logic v, input logic [W-1:0] d, input logic st, output logic acc);
    bus.in_valid = v;
    bus.in_data  = d;
    bus.start    = st;
    acc = v && (bus.in_ready === 1'b1);
    @(posedge clock); #1;
    bus.start    = 1'b0;
    bus.in_valid = 1'b0;
  endtask

  function automatic logic vpat(input int unsigned mode, input int unsigned cyc);
    if (mode == 0) return 1'b1;
    if (mode == 1) return (cyc % 3) == 0;
    return $urandom_range(0, 99) < 70;
  endfunction

  // One complete load: model expects writes k -> data_a[k], k = 0..n-1, when the header is legal.
  task automatic load_run(input logic [7:0] sync, input int unsigned n,
                          input int unsigned mode, input bit csum_bad);
    logic acc, v, st;
    bit hdr_ok;
    int unsigned base, cyc, tot;
    logic [W-1:0] hdr, xsum, cw;
    logic [7:0] n8;
    n8 = n[7:0];
    hdr_ok = (sync == 8'hA5) && (n >= 1) && (n <= NF);
    base = wr_cnt;
    tot = 0;
    hdr = {sync, 17'($urandom), n8};

    step(1'b1, hdr, 1'b1, acc);
    checks++;
    if (acc || bus.busy !== 1'b1 || bus.in_ready !== 1'b1 || bus.done !== 1'b0 ||
        bus.error !== 1'b0 || bus.frames_loaded !== '0) begin
      errors++;
      $display("FAIL start acc=%b busy=%b rdy=%b done=%b err=%b fl=%0d want 0 1 1 0 0 0",
               acc, bus.busy, bus.in_ready, bus.done, bus.error, bus.frames_loaded);
    end

    acc = 1'b0; cyc = 0;
    while (!acc && cyc < 100) begin
      v = vpat(mode, tot); tot++; cyc++;
      step(v, hdr, 1'b0, acc);
    end
    checks++;
    if (!acc) begin
      errors++; $display("FAIL header_timeout got no accept want accept");
      return;
    end

    if (!hdr_ok) begin
      checks++;
      if (bus.error !== 1'b1 || bus.busy !== 1'b0 || bus.in_ready !== 1'b0 ||
          bus.cfg_we !== 1'b0 || bus.fabric_en !== 1'b0 || bus.done !== 1'b0) begin
        errors++;
        $display("FAIL bad_header err=%b busy=%b rdy=%b we=%b en=%b done=%b want 1 0 0 0 0 0",
                 bus.error, bus.busy, bus.in_ready, bus.cfg_we, bus.fabric_en, bus.done);
      end
      step(1'b0, '0, 1'b0, acc);
      step(1'b0, '0, 1'b0, acc);
      checks++;
      if (wr_cnt - base != 0) begin
        errors++; $display("FAIL bad_header_writes got %0d want 0", wr_cnt - base);
      end
      return;
    end

    checks++;
    if (bus.busy !== 1'b1 || bus.cfg_we !== 1'b0 || bus.error !== 1'b0) begin
      errors++;
      $display("FAIL header_ok busy=%b we=%b err=%b want 1 0 0", bus.busy, bus.cfg_we, bus.error);
    end

    xsum = '0;
    for (int unsigned k = 0; k < n; k++) begin
      acc = 1'b0; cyc = 0;
      xsum ^= data_a[k];
      while (!acc && cyc < 100) begin
        v  = vpat(mode, tot); tot++; cyc++;
        st = (mode == 2) && ($urandom_range(0, 4) == 0);
        step(v, data_a[k], st, acc);
        checks++;
        if (acc) begin
          if (bus.cfg_we !== 1'b1 || bus.cfg_addr !== k[AW-1:0] ||
              bus.cfg_wdata !== data_a[k] || bus.frames_loaded !== CW'(k + 1)) begin
            errors++;
            $display("FAIL write we=%b addr=%0d data=%0h fl=%0d want 1 %0d %0h %0d",
                     bus.cfg_we, bus.cfg_addr, bus.cfg_wdata, bus.frames_loaded, k, data_a[k], k + 1);
          end
        end else if (bus.cfg_we !== 1'b0 || bus.frames_loaded !== CW'(k)) begin
          errors++;
          $display("FAIL stall we=%b fl=%0d want 0 %0d", bus.cfg_we, bus.frames_loaded, k);
        end
      end
      if (!acc) begin
        checks++; errors++;
        $display("FAIL data_timeout word %0d got no accept want accept", k);
        return;
      end
    end

`ifdef CFG_LOADER_CHECKSUM_EN
    checks++;
    if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
      errors++; $display("FAIL check_state busy=%b done=%b want 1 0", bus.busy, bus.done);
    end
    cw = csum_bad ? (xsum ^ W'(1)) : xsum;
    acc = 1'b0; cyc = 0;
    while (!acc && cyc < 100) begin
      v = vpat(mode, tot); tot++; cyc++;
      step(v, cw, 1'b0, acc);
    end
    checks++;
    if (!acc || bus.done !== !csum_bad || bus.error !== csum_bad || bus.fabric_en !== !csum_bad ||
        bus.cfg_we !== 1'b0 || bus.frames_loaded !== CW'(n)) begin
      errors++;
      $display("FAIL checksum acc=%b done=%b err=%b en=%b we=%b fl=%0d want 1 %b %b %b 0 %0d",
               acc, bus.done, bus.error, bus.fabric_en, bus.cfg_we, bus.frames_loaded,
               !csum_bad, csum_bad, !csum_bad, n);
    end
`else
    checks++;
    if (bus.done !== 1'b1 || bus.fabric_en !== 1'b1 || bus.busy !== 1'b0 ||
        bus.error !== 1'b0 || bus.frames_loaded !== CW'(n)) begin
      errors++;
      $display("FAIL done done=%b en=%b busy=%b err=%b fl=%0d want 1 1 0 0 %0d",
               bus.done, bus.fabric_en, bus.busy, bus.error, bus.frames_loaded, n);
    end
    xsum = xsum ^ xsum;
    cw = csum_bad ? '1 : '0;
    step(1'b1, cw, 1'b0, acc);
    checks++;
    if (acc || bus.cfg_we !== 1'b0 || bus.done !== 1'b1) begin
      errors++;
      $display("FAIL trailing acc=%b we=%b done=%b want 0 0 1", acc, bus.cfg_we, bus.done);
    end
`endif

    step(1'b0, '0, 1'b0, acc);
    step(1'b0, '0, 1'b0, acc);
    checks++;
    if (wr_cnt - base != n || bus.frames_loaded !== CW'(n)) begin
      errors++;
      $display("FAIL write_count got %0d fl=%0d want %0d", wr_cnt - base, bus.frames_loaded, n);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clock);
    #1;
    checks++;
    if (bus.in_ready !== 1'b0 || bus.cfg_we !== 1'b0 || bus.cfg_addr !== '0 || bus.cfg_wdata !== '0 ||
        bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.error !== 1'b0 || bus.fabric_en !== 1'b0 ||
        bus.frames_loaded !== '0) begin
      errors++; $display("FAIL reset outputs not all zero want all zero");
    end
    clear = 1'b0;
    @(posedge clock); #1;
    checks++;
    if (bus.in_ready !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL idle rdy=%b busy=%b done=%b want 0 0 0", bus.in_ready, bus.busy, bus.done);
    end
  endtask

  task automatic test_full_load();
    for (int unsigned k = 0; k < NF; k++) data_a[k] = 33'h1_0000_0000 + W'(k);
    load_run(8'hA5, NF, 0, 1'b0);
  endtask

  task automatic test_bad_sync();
    load_run(8'h5A, 4, 0, 1'b0);
    for (int unsigned k = 0; k < 3; k++) data_a[k] = W'($urandom);
    load_run(8'hA5, 3, 0, 1'b0);
  endtask

  task automatic test_bad_len();
    load_run(8'hA5, 15, 0, 1'b0);
    load_run(8'hA5, 0, 0, 1'b0);
    data_a[0] = 33'h1_2345_6789;
    load_run(8'hA5, 1, 0, 1'b0);
  endtask

  task automatic test_stall();
    for (int unsigned k = 0; k < 4; k++) data_a[k] = W'($urandom);
    load_run(8'hA5, 4, 1, 1'b0);
  endtask

  task automatic test_clear_midload();
    logic acc;
    step(1'b0, '0, 1'b1, acc);
    step(1'b1, {8'hA5, 17'h0, 8'd8}, 1'b0, acc);
    for (int unsigned k = 0; k < 3; k++) step(1'b1, W'(k + 100), 1'b0, acc);
    #2 clear = 1'b1;
    #1;
    checks++;
    if (bus.cfg_we !== 1'b0 || bus.in_ready !== 1'b0 || bus.busy !== 1'b0 ||
        bus.frames_loaded !== '0 || bus.done !== 1'b0 || bus.error !== 1'b0) begin
      errors++;
      $display("FAIL async_clear we=%b rdy=%b busy=%b fl=%0d want 0 0 0 0",
               bus.cfg_we, bus.in_ready, bus.busy, bus.frames_loaded);
    end
    @(posedge clock); #1;
    clear = 1'b0;
    for (int unsigned k = 0; k < 8; k++) data_a[k] = W'($urandom) ^ {1'b1, 32'h0};
    load_run(8'hA5, 8, 0, 1'b0);
  endtask

  task automatic test_checksum();
    data_a[0] = 33'h0F0F;
    data_a[1] = 33'h00FF;
    load_run(8'hA5, 2, 0, 1'b0);
    load_run(8'hA5, 2, 0, 1'b1);
  endtask

  task automatic test_random();
    for (int unsigned it = 0; it < 10; it++) begin
      int unsigned n;
      logic [7:0] sync;
      n = $urandom_range(1, NF);
      sync = ($urandom_range(0, 5) == 0) ? 8'(($urandom_range(0, 254) + 8'hA6)) : 8'hA5;
      for (int unsigned k = 0; k < n; k++) data_a[k] = W'({$urandom, $urandom});
      load_run(sync, n, 2, 1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    bus.start    = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    test_reset();
    test_full_load();
    test_bad_sync();
    test_bad_len();
    test_stall();
    test_clear_midload();
    test_checksum();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
